// File: rtl/demux_ctrl_pkg.sv
// demux_ctrl_pkg
//   Shared definitions for the packet demux controller: the controller FSM
//   state type, its width, and the default stall-timeout length.
//   Imported by demux_route_ctrl.
package demux_ctrl_pkg;

   localparam int STATE_W = 2;

   // IDLE    : waiting for a packet header beat
   // FWD     : forwarding body beats into the hold register
   // LAST    : last beat accepted, waiting for it to leave
   // DISCARD : dropping the remainder of a badly addressed packet
   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      FWD     = 2'd1,
      LAST    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   localparam int DEF_TMO = 15;

endpackage

// File: rtl/demux_1_n.sv
// demux_1_n
//   Combinational 1-to-NOUT steering of the valid bit by the select.
//   Data is broadcast unchanged to every consumer.
// Ports
//   sel        in   SELW   output select
//   valid      in   1      valid to steer
//   data       in   DW     beat data
//   out_valid  out  NOUT   one-hot valid (bit sel only)
//   out_data   out  DW     broadcast data
module demux_1_n #(
   parameter int DW   = 8,
   parameter int NOUT = 2,
   parameter int SELW = 1
) (
   input  logic [SELW-1:0] sel,
   input  logic            valid,
   input  logic [DW-1:0]   data,
   output logic [NOUT-1:0] out_valid,
   output logic [DW-1:0]   out_data
);

   generate
      for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
         assign out_valid[gi] = valid & (32'(sel) == 32'(gi));
      end
   endgenerate

   assign out_data = data;

endmodule

// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl
//   Packet-level sequencer for a 1-to-NOUT demux. Takes a valid/ready beat
//   stream, latches the destination from the header beat and holds the
//   select for the whole packet; the select is released only after the last
//   beat has left the one-entry hold register. Badly addressed packets are
//   dropped with a one-cycle err pulse.
//   Optional feature macro: DEMUX_TIMEOUT_EN -- drop a beat that has been
//   stalled by its consumer for TMO consecutive cycles.
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_data    in   DW     input beat data
//   in_dest    in   SELW   destination, sampled on the header beat only
//   in_last    in   1      final beat of a packet
//   in_valid   in   1      input beat valid
//   in_ready   out  1      controller can take a beat
//   out_sel    out  SELW   demux select, held for the whole packet
//   out_data   out  DW     registered beat data
//   out_valid  out  NOUT   one-hot valid at bit out_sel
//   out_ready  in   NOUT   per-output ready
//   busy       out  1      packet in flight
//   err        out  1      one-cycle pulse: bad dest or timeout drop
module demux_route_ctrl
   import demux_ctrl_pkg::*;
#(
   parameter int DW   = 8,
   parameter int NOUT = 2,
   parameter int SELW = 1,
   parameter int TMO  = DEF_TMO
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   in_data,
   input  logic [SELW-1:0] in_dest,
   input  logic            in_last,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [SELW-1:0] out_sel,
   output logic [DW-1:0]   out_data,
   output logic [NOUT-1:0] out_valid,
   input  logic [NOUT-1:0] out_ready,
   output logic            busy,
   output logic            err
);

   state_t          state_reg;
   logic [SELW-1:0] sel_reg;
   logic [DW-1:0]   data_reg;
   logic            valid_reg;
   logic            err_reg;
   logic            en_reg;      // holds in_ready low until the first edge after reset

   logic [NOUT-1:0] valid_vec;
   logic [DW-1:0]   data_fan;
   logic            drain;
   logic            xfer;
   logic            dest_ok;
   logic            tmo_hit;

   demux_1_n #(
      .DW   (DW),
      .NOUT (NOUT),
      .SELW (SELW)
   ) u_demux (
      .sel       (sel_reg),
      .valid     (valid_reg),
      .data      (data_reg),
      .out_valid (valid_vec),
      .out_data  (data_fan)
   );

   assign out_valid = valid_vec;
   assign out_data  = data_fan;
   assign out_sel   = sel_reg;
   assign busy      = (state_reg != IDLE);
   assign err       = err_reg;

   // valid_vec is one-hot at sel_reg, so this is out_ready[out_sel] gated by
   // a held beat, and readies of non-selected outputs never contribute.
   assign drain   = |(valid_vec & out_ready);
   assign dest_ok = (32'(in_dest) < 32'(NOUT));
   assign xfer    = in_valid & in_ready;

   always_comb begin
      in_ready = 1'b0;
      if (en_reg) begin
         if (state_reg == DISCARD)
            in_ready = 1'b1;
         else if (state_reg != LAST)
            in_ready = ~valid_reg | drain;
      end
   end

`ifdef DEMUX_TIMEOUT_EN
   localparam int CNTW = (TMO > 1) ? $clog2(TMO + 1) : 1;

   logic [CNTW-1:0] stall_cnt_reg;

   // Fires on the TMO-th consecutive stalled cycle of a held beat.
   assign tmo_hit = valid_reg & ~drain & (32'(stall_cnt_reg) == 32'(TMO - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_reg <= '0;
      else if (!valid_reg || drain || tmo_hit)
         stall_cnt_reg <= '0;
      else
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end
`else
   logic [31:0] tmo_unused;

   assign tmo_hit    = 1'b0;
   assign tmo_unused = 32'(TMO);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         sel_reg   <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         en_reg    <= 1'b0;
      end else begin
         en_reg  <= 1'b1;
         err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Hold register is always empty here, so the select may move.
               if (xfer) begin
                  if (dest_ok) begin
                     sel_reg   <= in_dest;
                     data_reg  <= in_data;
                     valid_reg <= 1'b1;
                     state_reg <= in_last ? LAST : FWD;
                  end else begin
                     err_reg   <= 1'b1;
                     state_reg <= in_last ? IDLE : DISCARD;
                  end
               end
            end
            FWD: begin
               // A load replaces the beat draining on the same edge: no bubble.
               if (xfer) begin
                  data_reg  <= in_data;
                  valid_reg <= 1'b1;
                  if (in_last)
                     state_reg <= LAST;
               end else if (drain || tmo_hit) begin
                  valid_reg <= 1'b0;
               end
               if (tmo_hit)
                  err_reg <= 1'b1;
            end
            LAST: begin
               if (drain || tmo_hit) begin
                  valid_reg <= 1'b0;
                  err_reg   <= tmo_hit;
                  state_reg <= IDLE;
               end
            end
            DISCARD: begin
               if (xfer && in_last)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_route_ctrl.sv
module tb_demux_route_ctrl;

   localparam int DW   = 8;
   localparam int NOUT = 2;
   localparam int SELW = 2;   // wider than needed so out-of-range dests can be driven

   typedef struct packed {
      logic [SELW-1:0] sel;
      logic [DW-1:0]   data;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   in_data = '0;
   logic [SELW-1:0] in_dest = '0;
   logic            in_last = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SELW-1:0] out_sel;
   logic [DW-1:0]   out_data;
   logic [NOUT-1:0] out_valid;
   logic [NOUT-1:0] out_ready;
   logic            busy;
   logic            err;

   beat_t exp_q[$];
   int    checks   = 0;
   int    errors   = 0;
   int    err_seen = 0;
   int    err_exp  = 0;
   bit    rand_rdy = 1'b0;
   bit    bubbles  = 1'b0;
   logic [NOUT-1:0] rdy_fixed = '1;

   demux_route_ctrl #(
      .DW   (DW),
      .NOUT (NOUT),
      .SELW (SELW),
      .TMO  (15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_dest   (in_dest),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sel   (out_sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Sole driver of out_ready: random per cycle or a fixed pattern.
   always @(posedge clk) begin
      #1;
      out_ready = rand_rdy ? NOUT'($urandom) : rdy_fixed;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: pops one expected beat per output transfer.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid != '0)
            chk("onehot_at_sel", 32'(out_valid & ~(NOUT'(1) << out_sel)), 32'd0);
         if ((out_valid & out_ready) != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got sel=%0d data=0x%0h expected none", out_sel, out_data);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               $display("out beat sel=%0d data=0x%0h", out_sel, out_data);
               chk("beat", {22'd0, out_sel, out_data}, {22'd0, e.sel, e.data});
            end
         end
         if (err)
            err_seen++;
      end
   end

   task automatic set_rdy(input logic [NOUT-1:0] v);
      rdy_fixed = v;
      @(posedge clk);
      #2;
   endtask

   // Reference model: a packet with an in-range dest yields its beats, in
   // order, on that output; any other dest yields exactly one err pulse.
   task automatic send_pkt(input logic [SELW-1:0] dest, input logic [DW-1:0] d[$]);
      bit bad;
      bit ok;
      bad = (32'(dest) >= 32'(NOUT));
      if (bad)
         err_exp++;
      $display("in  pkt dest=%0d beats=%0d", dest, d.size());
      for (int i = 0; i < d.size(); i++) begin
         beat_t b;
         if (!bad) begin
            b.sel  = dest;
            b.data = d[i];
            exp_q.push_back(b);
         end
         in_valid = 1'b1;
         in_dest  = (i == 0) ? dest : SELW'($urandom);
         in_data  = d[i];
         in_last  = (i == d.size() - 1);
         ok = 1'b0;
         for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (in_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (bubbles && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 500 && (exp_q.size() != 0 || busy); t++)
         @(negedge clk);
      chk("drain_idle", {30'd0, exp_q.size() != 0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0]   d[$];
      logic [SELW-1:0] dest;
      int              len;
      int              err_before;
      bit              ok;

      // Reset state
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sel",   32'(out_sel),   32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_err",       32'(err),       32'd0);
      #14 rst = 1'b0;
      @(negedge clk);
      chk("ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_edge", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // T1: 3-beat packet to output 1, consumers always ready
      set_rdy(2'b11);
      send_pkt(2'd1, '{8'hA1, 8'hA2, 8'hA3});
      @(negedge clk);
      chk("t1_busy_last", 32'(busy), 32'd1);
      chk("t1_out_valid", 32'(out_valid), 32'b10);
      @(negedge clk);
      chk("t1_busy_fall", 32'(busy), 32'd0);
      wait_idle();

      // T2: single-beat packet to output 0
      send_pkt(2'd0, '{8'h55});
      @(negedge clk);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_in_ready_last", 32'(in_ready), 32'd0);
      chk("t2_out_valid", 32'(out_valid), 32'b01);
      @(negedge clk);
      chk("t2_busy_fall", 32'(busy), 32'd0);
      wait_idle();

      // T3: output 0 stalled for 4 cycles during a 2-beat packet
      set_rdy(2'b10);   // non-selected output ready must be ignored
      fork
         send_pkt(2'd0, '{8'h11, 8'h22});
         begin
            for (int t = 0; t < 50 && out_valid == '0; t++)
               @(negedge clk);
            chk("t3_loaded", 32'(out_valid), 32'b01);
            repeat (4) begin
               @(negedge clk);
               chk("t3_hold_data", 32'(out_data), 32'h11);
               chk("t3_in_ready", 32'(in_ready), 32'd0);
               chk("t3_out_sel", 32'(out_sel), 32'd0);
            end
            set_rdy(2'b11);
         end
      join
      wait_idle();

      // T4: out-of-range destination, 2 beats
      err_before = err_seen;
      send_pkt(2'd3, '{8'hC1, 8'hC2});
      @(negedge clk);
      chk("t4_err_once", 32'(err_seen - err_before), 32'd1);
      chk("t4_no_valid", 32'(out_valid), 32'd0);
      chk("t4_idle", 32'(busy), 32'd0);
      wait_idle();

      // T6: no timeout logic in this build -- beat held indefinitely
      set_rdy(2'b00);
      send_pkt(2'd1, '{8'h99});
      repeat (100) @(negedge clk);
      chk("t6_still_valid", 32'(out_valid), 32'b10);
      chk("t6_still_data", 32'(out_data), 32'h99);
      set_rdy(2'b11);
      wait_idle();

      // T5: reset mid-packet, the held beat is lost
      set_rdy(2'b00);
      in_valid = 1'b1;
      in_dest  = 2'd1;
      in_data  = 8'hE1;
      in_last  = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t5_first_beat_taken", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      set_rdy(2'b11);
      send_pkt(2'd0, '{8'h77});
      wait_idle();

      // Randomized packets with random consumer readiness and input bubbles
      rand_rdy = 1'b1;
      bubbles  = 1'b1;
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 4);
         d = {};
         for (int i = 0; i < len; i++)
            d.push_back(DW'($urandom));
         dest = ($urandom_range(0, 7) == 0) ? SELW'($urandom_range(2, 3))
                                            : SELW'($urandom_range(0, 1));
         send_pkt(dest, d);
      end
      wait_idle();
      rand_rdy = 1'b0;
      bubbles  = 1'b0;
      repeat (3) @(negedge clk);

      chk("err_total", 32'(err_seen), 32'(err_exp));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
